// File: rtl/uart_recv.sv
// 8N1 UART receiver: 2-FF line synchroniser, mid-bit sampling,
// one-cycle valid / frame_err pulses with data held between frames.
module uart_recv #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;

  localparam logic [13:0] BAUD_END = 14'(BAUD_DIV - 1);
  localparam logic [13:0] HALF_END = 14'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic [13:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign rx_s = sync_q[1];
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        DATA: begin
          if (cnt == BAUD_END) begin
            cnt     <= '0;
            sh[idx] <= rx_s;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        STOP: begin
          if (cnt == BAUD_END) begin
            cnt <= '0;
            // Leave mid stop bit so a back-to-back start edge is caught
            if (rx_s) begin
              data  <= sh;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 14'd1;
          end
        end
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 16 clocks per bit.
// Pulses are logged by a monitor; expectations are hand-computed.
module tb_uart_recv;

  localparam int BD = 16;
  localparam int HD = 8;
  // 2 sync FFs + IDLE->START edge + half bit + 9 bit periods
  localparam int LAT = 3 + HD + 9 * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt = 0;
  int fcnt = 0;
  int both = 0;
  int vt [0:31];
  logic [7:0] vd [0:31];

  uart_recv #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .valid    (valid),
    .data     (data),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && vcnt < 32) begin
      vt[vcnt] = cyc;
      vd[vcnt] = data;
    end
    if (valid) vcnt = vcnt + 1;
    if (frame_err) fcnt = fcnt + 1;
    if (valid && frame_err) both = both + 1;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input logic       stop
  );
    din = 1'b0;
    wait_clks(BD);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      wait_clks(BD);
    end
    din = stop;
    wait_clks(BD);
  endtask

  int t0;
  int v0;
  int f0;

  initial begin
    wait_clks(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(4);

    // Single good frame
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    wait_clks(5);
    check("a5_vcnt", 32'(vcnt), 32'd1);
    check("a5_data", 32'(vd[0]), 32'hA5);
    check("a5_lat", 32'(vt[0] - t0), 32'(LAT));
    check("a5_ferr", 32'(fcnt), 32'd0);
    check("a5_busy", 32'(busy), 32'd0);

    // Start glitch of 3 clocks
    din = 1'b0;
    wait_clks(3);
    check("gl_busy_hi", 32'(busy), 32'd1);
    din = 1'b1;
    wait_clks(HD + 3);
    check("gl_busy_lo", 32'(busy), 32'd0);
    check("gl_vcnt", 32'(vcnt), 32'd1);
    check("gl_ferr", 32'(fcnt), 32'd0);
    wait_clks(4);

    // Bad stop bit followed by a held break
    send_frame(8'h3C, 1'b0);
    check("fe_fcnt", 32'(fcnt), 32'd1);
    check("fe_vcnt", 32'(vcnt), 32'd1);
    check("fe_data", 32'(data), 32'hA5);
    wait_clks(40);
    check("fe_busy_brk", 32'(busy), 32'd1);
    din = 1'b1;
    wait_clks(1);
    check("fe_busy_rise", 32'(busy), 32'd1);
    wait_clks(3);
    check("fe_busy_lo", 32'(busy), 32'd0);
    wait_clks(20);
    check("fe_noretrig", 32'(fcnt), 32'd1);
    check("fe_busy_idle", 32'(busy), 32'd0);

    // Back-to-back frames with no idle gap
    v0 = vcnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clks(5);
    check("bb_vcnt", 32'(vcnt - v0), 32'd2);
    check("bb_d0", 32'(vd[v0]), 32'h00);
    check("bb_d1", 32'(vd[v0 + 1]), 32'hFF);
    check("bb_gap", 32'(vt[v0 + 1] - vt[v0]), 32'd160);
    check("bb_ferr", 32'(fcnt), 32'd1);

    // Reset during bit 4 of 0xF0 (bits 4..7 and stop high)
    v0 = vcnt;
    f0 = fcnt;
    din = 1'b0;
    wait_clks(5 * BD);
    din = 1'b1;
    wait_clks(8);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check("rr_data", 32'(data), 32'h00);
    check("rr_busy", 32'(busy), 32'd0);
    wait_clks(7 + 4 * BD + 8);
    check("rr_vcnt", 32'(vcnt - v0), 32'd0);
    check("rr_fcnt", 32'(fcnt - f0), 32'd0);
    check("rr_data2", 32'(data), 32'h00);
    send_frame(8'h5A, 1'b1);
    wait_clks(5);
    check("rr_5a_vcnt", 32'(vcnt - v0), 32'd1);
    check("rr_5a_data", 32'(data), 32'h5A);
    check("rr_5a_ferr", 32'(fcnt - f0), 32'd0);

    check("excl", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
